// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy encoding and bubble instruction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_skid_reg_pkg;

    // Stage occupancy: no entry, main entry only, main plus skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // Instruction word shown downstream while the stage holds nothing.
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_payload_reg.sv
// One storage entry of the skid stage: a width-parametrised register with load enable and clear.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load. Clear wins over load.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset and flush both empty the entry to zero; otherwise capture on load.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register carrying instr/pc/pc8/exc; in_ready is decoded from registered state only.
// Latency: 1 cycle from input transfer to out_valid; full throughput under sustained valid/ready.
// Backpressure: second entry absorbs one beat while out_ready is low; in_ready drops only when both entries are occupied.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter int                 EXC_W     = 5,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [PC_W-1:0]    in_pc8,
    input  logic [EXC_W-1:0]   in_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc8,
    output logic [EXC_W-1:0]   out_exc,
    output logic               full
);

    localparam int PAY_W = INSTR_W + 2 * PC_W + EXC_W;

    skid_state_t      state;
    skid_state_t      state_nxt;
    logic [PAY_W-1:0] in_bus;
    logic [PAY_W-1:0] main_d;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] skid_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_load;
    logic             skid_load;

    assign in_bus = {in_instr, in_pc, in_pc8, in_exc};

    // Handshake flags come straight from the state register, so in_ready has no path from out_ready.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign full      = (state == ST_FULL);

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Next occupancy and entry load strobes; flush/reset priority is applied in the registers.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_bus;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    // Pass-through: main is consumed and refilled in the same edge.
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new beat behind main.
                    skid_load = 1'b1;
                    state_nxt = ST_FULL;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain case exists.
                if (out_xfer) begin
                    main_d    = skid_q;
                    main_load = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Occupancy register: reset over flush over normal transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else if (clr) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    pipe_payload_reg #(
        .W (PAY_W)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_payload_reg #(
        .W (PAY_W)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .load  (skid_load),
        .d     (in_bus),
        .q     (skid_q)
    );

    // Bubbles present the NOP instruction with all other fields zero, whatever main still holds.
    assign {out_instr, out_pc, out_pc8, out_exc} =
        out_valid ? main_q : {NOP_INSTR, {(PAY_W - INSTR_W){1'b0}}};

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter INSTR_W, default 32, instruction field width.
REQ-002 Parameter PC_W, default 32, width of both PC fields.
REQ-003 Parameter EXC_W, default 5, exception-code field width.
REQ-004 Parameter NOP_INSTR, default 0 (INSTR_W bits), instruction presented on a bubble.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clr  in  1  synchronous flush, active-high; discards stage contents.
REQ-008 in_valid  in  1  upstream offers a payload.
REQ-009 in_ready  out  1  stage can accept; registered, never combinationally dependent on out_ready.
REQ-010 in_instr / in_pc / in_pc8 / in_exc  in  INSTR_W / PC_W / PC_W / EXC_W  upstream payload.
REQ-011 out_valid  out  1  payload presented downstream.
REQ-012 out_ready  in  1  downstream accepts (deasserted = stall).
REQ-013 out_instr / out_pc / out_pc8 / out_exc  out  INSTR_W / PC_W / PC_W / EXC_W  presented payload.
REQ-014 full  out  1  both storage entries occupied (status only).

Function
REQ-015 Input transfer SHALL occur exactly when in_valid && in_ready at a rising edge; output transfer exactly when out_valid && out_ready.
REQ-016 Storage SHALL be two entries: main (drives outputs) and skid; state SHALL be one of EMPTY, ONE, FULL.
REQ-017 EMPTY + input transfer -> ONE, payload loaded into main; out_valid asserts the following cycle (latency 1).
REQ-018 ONE + input transfer + output transfer -> ONE, main reloaded with input payload.
REQ-019 ONE + output transfer, no input transfer -> EMPTY.
REQ-020 ONE + input transfer, no output transfer -> FULL, payload loaded into skid.
REQ-021 FULL + output transfer -> ONE, skid contents moved into main; no input transfer possible since in_ready = 0.
REQ-022 All other combinations SHALL hold state and contents unchanged.
REQ-023 in_ready SHALL equal (state != FULL); full SHALL equal (state == FULL); out_valid SHALL equal (state != EMPTY).
REQ-024 When out_valid = 0, out_instr SHALL be NOP_INSTR and out_pc, out_pc8, out_exc SHALL be 0.
REQ-025 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by clr/reset.
REQ-026 Sustained in_valid = out_ready = 1 SHALL give one transfer per cycle with no bubbles.
REQ-027 clr SHALL, at the next edge, force EMPTY regardless of concurrent transfers; any input offered in the clr cycle is discarded.
REQ-028 reset SHALL take priority over clr; clr SHALL take priority over all transfers.
REQ-029 in_valid while in_ready = 0 SHALL have no effect; upstream holds the payload.

Reset
REQ-030 On reset: state EMPTY, in_ready = 1, out_valid = 0, full = 0, out_instr = NOP_INSTR, other outputs 0, skid contents 0.
REQ-031 Reset asserted mid-operation SHALL discard both entries at the next edge without emitting them.
REQ-032 No initial blocks SHALL be relied on for reset values; reset is the only initialisation.

Structure
REQ-033 Shared package SHALL hold the state encoding (EMPTY/ONE/FULL) and the default NOP_INSTR constant.
REQ-034 Payload SHALL be handled as one concatenated bus of INSTR_W + 2*PC_W + EXC_W bits internally.
REQ-035 One sub-module pipe_payload_reg (width-parametrised, load-enable, sync clear) SHALL implement each of the two entries.

Verification
REQ-036 reset, then in_valid=1, instr=0x24020005, pc=0x3000, pc8=0x3008, out_ready=1 -> next cycle out_valid=1, out_instr=0x24020005, out_pc=0x3000.
REQ-037 Stream 0x1..0x8 with out_ready=1 throughout -> outputs 0x1..0x8 on 8 consecutive cycles, in_ready constantly 1.
REQ-038 Load 0xA, 0xB with out_ready=0 -> full=1, in_ready=0; third offer 0xC held; raise out_ready -> outputs 0xA, 0xB, 0xC in order.
REQ-039 FULL with 0xA/0xB, assert clr with in_valid=1, instr=0xC -> next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1; 0xC never emitted.
REQ-040 Assert reset and clr together in FULL with out_ready=1 -> next cycle EMPTY, no output transfer observed downstream after the edge.
REQ-041 Randomised in_valid/out_ready for 10000 cycles vs scoreboard -> zero order/loss/duplication errors, in_ready never combinationally follows out_ready.
